// File: rtl/conv3x3_engine.sv
// ---------------------------------------------------------------------------
// | Module  : conv3x3_engine                                                |
// | Purpose : 3-stage 3x3 convolution (Gaussian/Sobel/sharpen/pass-through)  |
// |           with per-frame mode latching and frame-end signalling.        |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module conv3x3_engine #(
  parameter int N    = 399,
  parameter int ROWS = 397
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] pixel_in,
  input  logic        in_valid,
  input  logic [1:0]  mode,
  output logic [7:0]  pixel_out,
  output logic        out_valid,
  output logic        sat_flag,
  output logic        frame_done
);

  localparam int              c_TOTAL = (N + 1) * ROWS;
  localparam int              c_CW    = $clog2(c_TOTAL + 1);
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_TOTAL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_accept, w_last;
  logic [c_CW-1:0]   r_count;
  logic [1:0]        r_mode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_count == c_LAST);
    case (r_state)
      IDLE, RUN: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_last ? FLUSH : RUN;
        end
      end
      FLUSH:   if (frame_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_mode_q <= 2'd0;
    end else begin
      if (r_state == FLUSH && frame_done) r_count <= '0;
      else if (w_accept)                  r_count <= r_count + c_CW'(1);
      if (w_accept && r_state == IDLE)    r_mode_q <= mode;
    end
  end

  // S1: window register; the last-of-frame marker travels with the data
  logic        r_s1_valid, r_s1_last;
  logic [35:0] r_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_win      <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && w_last;
      if (w_accept) r_win <= pixel_in;
    end
  end

  logic [3:0] w_p [3][3];

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign w_p[r][c] = r_win[35-12*r-4*c -: 4];
    end
  end

  // S2: partial sums
  logic [7:0]        w_gauss, w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [8:0] w_gx, w_gy;
  logic [6:0]        w_sh_pos;
  logic [5:0]        w_sh_neg;

  always_comb begin
    w_gauss  = {4'b0, w_p[0][0]} + {4'b0, w_p[0][2]} + {4'b0, w_p[2][0]} + {4'b0, w_p[2][2]}
             + {3'b0, w_p[0][1], 1'b0} + {3'b0, w_p[1][0], 1'b0}
             + {3'b0, w_p[1][2], 1'b0} + {3'b0, w_p[2][1], 1'b0}
             + {2'b0, w_p[1][1], 2'b0};
    w_gx_pos = {4'b0, w_p[0][2]} + {3'b0, w_p[1][2], 1'b0} + {4'b0, w_p[2][2]};
    w_gx_neg = {4'b0, w_p[0][0]} + {3'b0, w_p[1][0], 1'b0} + {4'b0, w_p[2][0]};
    w_gy_pos = {4'b0, w_p[2][0]} + {3'b0, w_p[2][1], 1'b0} + {4'b0, w_p[2][2]};
    w_gy_neg = {4'b0, w_p[0][0]} + {3'b0, w_p[0][1], 1'b0} + {4'b0, w_p[0][2]};
    w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
    w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
    w_sh_pos = {1'b0, w_p[1][1], 2'b0} + {3'b0, w_p[1][1]};
    w_sh_neg = {2'b0, w_p[0][1]} + {2'b0, w_p[1][0]} + {2'b0, w_p[1][2]} + {2'b0, w_p[2][1]};
  end

  logic              r_s2_valid, r_s2_last;
  logic [7:0]        r_gauss;
  logic signed [8:0] r_gx, r_gy;
  logic [6:0]        r_sh_pos;
  logic [5:0]        r_sh_neg;
  logic [3:0]        r_p11;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_gauss    <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_sh_pos   <= '0;
      r_sh_neg   <= '0;
      r_p11      <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_gauss  <= w_gauss;
        r_gx     <= w_gx;
        r_gy     <= w_gy;
        r_sh_pos <= w_sh_pos;
        r_sh_neg <= w_sh_neg;
        r_p11    <= w_p[1][1];
      end
    end
  end

  // S3: kernel select, clamp, register
  logic [7:0]        w_abs_gx, w_abs_gy, w_res;
  logic signed [8:0] w_sharp;
  logic              w_sat;

  always_comb begin
    w_abs_gx = r_gx[8] ? 8'(-r_gx) : r_gx[7:0];
    w_abs_gy = r_gy[8] ? 8'(-r_gy) : r_gy[7:0];
    w_sharp  = $signed({2'b0, r_sh_pos}) - $signed({3'b0, r_sh_neg});
    w_res    = 8'd0;
    w_sat    = 1'b0;
    case (r_mode_q)
      2'd0:    w_res = r_gauss;
      2'd1:    w_res = w_abs_gx + w_abs_gy;
      2'd2: begin
        if (w_sharp[8]) w_sat = 1'b1;
        else            w_res = w_sharp[7:0];
      end
      default: w_res = {4'b0, r_p11};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_out  <= 8'd0;
      out_valid  <= 1'b0;
      sat_flag   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_s2_valid;
      frame_done <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        pixel_out <= w_res;
        sat_flag  <= w_sat;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
// ---------------------------------------------------------------------------
// | Module  : tb_conv3x3_engine                                             |
// | Purpose : directed self-checking bench for conv3x3_engine (N=3,ROWS=2)  |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv3x3_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [35:0] pixel_in = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  pixel_out;
  logic        out_valid, sat_flag, frame_done;

  conv3x3_engine #(.N(3), .ROWS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .in_valid   (in_valid),
    .mode       (mode),
    .pixel_out  (pixel_out),
    .out_valid  (out_valid),
    .sat_flag   (sat_flag),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_stray_fd = 0;
  logic [7:0] q_pix[$];
  logic       q_fd[$];
  int         q_cyc[$];
  int         acc[8];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      q_pix.push_back(pixel_out);
      q_fd.push_back(frame_done);
      q_cyc.push_back(cyc);
    end else if (frame_done) begin
      n_stray_fd++;
    end
  end

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("rst_out_valid", 36'(out_valid), 36'd0);
    check("rst_pixel_out", 36'(pixel_out), 36'd0);
    check("rst_sat_flag", 36'(sat_flag), 36'd0);
    check("rst_frame_done", 36'(frame_done), 36'd0);
    tick();
    reset = 1'b1;
  endtask

  task automatic shot(input string tag, input logic [1:0] m, input logic [35:0] w,
                      input logic [7:0] exp_pix, input logic exp_sat);
    do_reset();
    mode     = m;
    pixel_in = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mode     = m ^ 2'b01;
    check({tag, "_lat1"}, 36'(out_valid), 36'd0);
    tick();
    check({tag, "_lat2"}, 36'(out_valid), 36'd0);
    tick();
    check({tag, "_valid"}, 36'(out_valid), 36'd1);
    check({tag, "_pix"}, 36'(pixel_out), 36'(exp_pix));
    check({tag, "_sat"}, 36'(sat_flag), 36'(exp_sat));
    check({tag, "_fd"}, 36'(frame_done), 36'd0);
    tick();
    check({tag, "_drop"}, 36'(out_valid), 36'd0);
    check({tag, "_hold"}, 36'(pixel_out), 36'(exp_pix));
    check({tag, "_hold_sat"}, 36'(sat_flag), 36'(exp_sat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfd;
    #3;
    do_reset();

    shot("gauss_max",  2'd0, 36'hFFFFFFFFF, 8'd240, 1'b0);
    shot("gauss_mix",  2'd0, 36'h123456789, 8'd80,  1'b0);
    shot("sobel_gx",   2'd1, 36'h07F07F07F, 8'd60,  1'b0);
    shot("sobel_gy",   2'd1, 36'h000777FFF, 8'd60,  1'b0);
    shot("sobel_ngy",  2'd1, 36'hFFF777000, 8'd60,  1'b0);
    shot("sobel_mix",  2'd1, 36'h123456789, 8'd32,  1'b0);
    shot("sharp_clmp", 2'd2, 36'hFFFF0FFFF, 8'd0,   1'b1);
    shot("sharp_max",  2'd2, 36'h0000F0000, 8'd75,  1'b0);
    shot("sharp_mix",  2'd2, 36'h123456789, 8'd5,   1'b0);
    shot("pass",       2'd3, 36'h123456789, 8'd5,   1'b0);

    // reset asserted mid-frame must clear outputs before the next edge
    do_reset();
    mode     = 2'd0;
    pixel_in = 36'hFFFFFFFFF;
    in_valid = 1'b1;
    repeat (3) tick();
    check("mid_pre_valid", 36'(out_valid), 36'd1);
    check("mid_pre_pix", 36'(pixel_out), 36'd240);
    #2 reset = 1'b0;
    #1;
    check("mid_valid", 36'(out_valid), 36'd0);
    check("mid_pix", 36'(pixel_out), 36'd0);
    check("mid_sat", 36'(sat_flag), 36'd0);
    check("mid_fd", 36'(frame_done), 36'd0);
    in_valid = 1'b0;
    tick();
    check("mid_hold_valid", 36'(out_valid), 36'd0);
    reset = 1'b1;
    tick();

    // full frame with gaps, mode change mid-frame, extra input during flush
    q_pix.delete(); q_fd.delete(); q_cyc.delete();
    n_stray_fd = 0;
    mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      pixel_in = 36'(i + 1) << 16;
      in_valid = 1'b1;
      tick();
      acc[i]   = cyc;
      in_valid = 1'b0;
      if (i == 2) mode = 2'd0;
      if (i % 3 == 1) begin
        tick();
        tick();
      end
    end
    pixel_in = 36'h0000F0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("frm_count", 36'(q_pix.size()), 36'd8);
    for (int k = 0; k < q_pix.size() && k < 8; k++) begin
      check($sformatf("frm_pix%0d", k), 36'(q_pix[k]), 36'(k + 1));
      check($sformatf("frm_fd%0d", k), 36'(q_fd[k]), 36'(k == 7));
      check($sformatf("frm_cyc%0d", k), 36'(q_cyc[k]), 36'(acc[k] + 2));
    end
    check("frm_stray_fd", 36'(n_stray_fd), 36'd0);

    // two frames back to back with in_valid held high
    q_pix.delete(); q_fd.delete(); q_cyc.delete();
    mode     = 2'd3;
    pixel_in = 36'h000030000;
    in_valid = 1'b1;
    nfd      = 0;
    for (int c = 0; c < 80 && nfd < 2; c++) begin
      tick();
      if (frame_done) begin
        nfd++;
        if (nfd == 1) mode = 2'd2;
      end
    end
    in_valid = 1'b0;
    check("b2b_frames", 36'(nfd), 36'd2);
    repeat (6) tick();
    check("b2b_count", 36'(q_pix.size()), 36'd16);
    for (int k = 0; k < q_pix.size() && k < 16; k++) begin
      check($sformatf("b2b_pix%0d", k), 36'(q_pix[k]), (k < 8) ? 36'd3 : 36'd15);
      check($sformatf("b2b_fd%0d", k), 36'(q_fd[k]), 36'(k == 7 || k == 15));
    end
    check("b2b_stray_fd", 36'(n_stray_fd), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
